// File: rtl/fix2sfp_pipe.sv
// Multi-lane 3-stage converter from two's-complement fixed-point sums to SFP {sign|exp|mant},
// with optional round-to-nearest-even, exponent saturation flags and a valid/ready handshake.
module fix2sfp_pipe #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2,
    parameter int LANES      = 4,
    parameter int ROUND_EN   = 1,
    localparam int FIX_W       = sigWidth + 4 + low_expand,
    localparam int formatWidth = 1 + expWidth + sigWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*FIX_W-1:0]       fixin,
    input  logic [LANES*expWidth-1:0]    max_exp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*formatWidth-1:0] sfpout,
    output logic [LANES-1:0]             ovf_flag,
    output logic [LANES-1:0]             unf_flag,
    input  logic                         clr_flags
);

    localparam int L_W = $clog2(FIX_W);
    localparam int E_W = expWidth + 2;
    localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << expWidth) - 1);
    localparam logic signed [E_W-1:0] EOFF_BIAS = E_W'(sigWidth - 1 + low_expand);

    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [FIX_W-1:0]    mag;
        logic [expWidth-1:0] max_exp;
    } s1_t;

    typedef struct packed {
        logic                  sign;
        logic                  zero;
        logic [sigWidth-1:0]   mant;
        logic                  guard;
        logic                  sticky;
        logic signed [E_W-1:0] eoff;
        logic [expWidth-1:0]   max_exp;
    } s2_t;

    logic adv;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic out_valid_d, out_valid_q;

    // The whole pipeline moves as one; only a stalled, occupied output register blocks it.
    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            s1_valid_d  = in_valid;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [FIX_W-1:0]       fix;
        logic [FIX_W-1:0]       fix_neg;
        s1_t                    s1_d, s1_q;
        s2_t                    s2_d, s2_q;
        logic [formatWidth-1:0] sfp_n, sfp_d, sfp_q;
        logic                   ovf_d, ovf_q, unf_d, unf_q;
        logic [L_W-1:0]         lead;
        logic [FIX_W-1:0]       norm;
        logic                   round_up;
        logic [sigWidth:0]      mant_rnd;
        logic [sigWidth-1:0]    mant_fin;
        logic signed [E_W-1:0]  eoff_adj;
        logic signed [E_W-1:0]  e;
        logic                   ovf_set, unf_set;

        assign fix     = fixin[g*FIX_W +: FIX_W];
        assign fix_neg = -fix;

        // S1: sign/magnitude split; the magnitude is unsigned so the most negative input is exact.
        always_comb begin
            s1_d = s1_q;
            if (adv) begin
                s1_d.sign    = fix[FIX_W-1];
                s1_d.zero    = (fix == '0);
                s1_d.mag     = fix[FIX_W-1] ? fix_neg : fix;
                s1_d.max_exp = max_exp[g*expWidth +: expWidth];
            end
        end

        // S2: normalise so the leading one sits at the MSB; zero-fill covers short magnitudes.
        always_comb begin
            lead = '0;
            for (int b = 0; b < FIX_W; b++) begin
                if (s1_q.mag[b]) lead = L_W'(b);
            end
            norm = s1_q.mag << (L_W'(FIX_W - 1) - lead);
            s2_d = s2_q;
            if (adv) begin
                s2_d.sign    = s1_q.sign;
                s2_d.zero    = s1_q.zero;
                s2_d.mant    = norm[FIX_W-1 -: sigWidth];
                s2_d.guard   = norm[FIX_W-1-sigWidth];
                s2_d.sticky  = |norm[FIX_W-2-sigWidth:0];
                s2_d.eoff    = E_W'(lead) - EOFF_BIAS;
                s2_d.max_exp = s1_q.max_exp;
            end
        end

        // S3: round, renormalise on carry, then place the exponent against the block exponent.
        always_comb begin
            round_up = (ROUND_EN != 0) && s2_q.guard && (s2_q.sticky || s2_q.mant[0]);
            mant_rnd = {1'b0, s2_q.mant} + {{sigWidth{1'b0}}, round_up};
            if (mant_rnd[sigWidth]) begin
                mant_fin = {1'b1, {(sigWidth-1){1'b0}}};
                eoff_adj = s2_q.eoff + E_W'(1);
            end else begin
                mant_fin = mant_rnd[sigWidth-1:0];
                eoff_adj = s2_q.eoff;
            end
            e       = $signed({2'b00, s2_q.max_exp}) + eoff_adj;
            ovf_set = 1'b0;
            unf_set = 1'b0;
            if (s2_q.zero) begin
                sfp_n = '0;
            end else if (e > EXP_MAX) begin
                sfp_n   = {s2_q.sign, {expWidth{1'b1}}, {sigWidth{1'b1}}};
                ovf_set = 1'b1;
            end else if (e[E_W-1]) begin
                sfp_n   = {s2_q.sign, {expWidth{1'b0}}, mant_fin};
                unf_set = 1'b1;
            end else begin
                sfp_n = {s2_q.sign, e[expWidth-1:0], mant_fin};
            end
            sfp_d = (adv && s2_valid_q) ? sfp_n : sfp_q;
            ovf_d = (ovf_q & ~clr_flags) | (adv & s2_valid_q & ovf_set);
            unf_d = (unf_q & ~clr_flags) | (adv & s2_valid_q & unf_set);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q  <= '0;
                s2_q  <= '0;
                sfp_q <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                s1_q  <= s1_d;
                s2_q  <= s2_d;
                sfp_q <= sfp_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end

        assign sfpout[g*formatWidth +: formatWidth] = sfp_q;
        assign ovf_flag[g] = ovf_q;
        assign unf_flag[g] = unf_q;
    end

endmodule

// File: tb/tb_fix2sfp_pipe.sv
// Directed bench for fix2sfp_pipe: a rounding and a truncating instance share one stimulus stream.
module tb_fix2sfp_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr_flags;
    logic        in_ready, out_valid, t_in_ready, t_out_valid;
    logic [39:0] fixin;
    logic [15:0] max_exp;
    logic [35:0] sfpout, t_sfpout;
    logic [3:0]  ovf_flag, unf_flag, t_ovf_flag, t_unf_flag;
    logic [9:0]  fx [4];
    logic [3:0]  me [4];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign fixin   = {fx[3], fx[2], fx[1], fx[0]};
    assign max_exp = {me[3], me[2], me[1], me[0]};

    fix2sfp_pipe #(.expWidth(4), .sigWidth(4), .low_expand(2), .LANES(4), .ROUND_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fixin(fixin),
        .max_exp(max_exp), .out_valid(out_valid), .out_ready(out_ready), .sfpout(sfpout),
        .ovf_flag(ovf_flag), .unf_flag(unf_flag), .clr_flags(clr_flags)
    );

    fix2sfp_pipe #(.expWidth(4), .sigWidth(4), .low_expand(2), .LANES(4), .ROUND_EN(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .fixin(fixin),
        .max_exp(max_exp), .out_valid(t_out_valid), .out_ready(out_ready), .sfpout(t_sfpout),
        .ovf_flag(t_ovf_flag), .unf_flag(t_unf_flag), .clr_flags(clr_flags)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [35:0] pk(input logic [8:0] l0, input logic [8:0] l1,
                                       input logic [8:0] l2, input logic [8:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic set_lanes(input logic [9:0] f0, input logic [9:0] f1, input logic [9:0] f2,
                             input logic [9:0] f3, input logic [3:0] m0, input logic [3:0] m1,
                             input logic [3:0] m2, input logic [3:0] m3);
        fx[0] = f0; fx[1] = f1; fx[2] = f2; fx[3] = f3;
        me[0] = m0; me[1] = m1; me[2] = m2; me[3] = m3;
    endtask

    // Called at a falling edge with lanes already set: one beat in, checked exactly 3 edges later.
    task automatic run_one(input string tag, input logic [35:0] exp_rnd, input logic [35:0] exp_trn);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_rnd"}, sfpout, exp_rnd);
        check({tag, "_trn"}, t_sfpout, exp_trn);
    endtask

    initial begin
        int          sent = 0;
        int          rcv  = 0;
        logic        stalled = 1'b0;
        logic [35:0] held = '0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
        set_lanes(10'd0, 10'd0, 10'd0, 10'd0, 4'd5, 4'd5, 4'd5, 4'd5);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sfpout", sfpout, 36'd0);
        check("rst_flags", {ovf_flag, unf_flag}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // +64, -64, zero (block exponent 0, must not flag), 92 (tie with odd mantissa)
        set_lanes(10'd64, 10'h3C0, 10'd0, 10'd92, 4'd5, 4'd5, 4'd0, 4'd5);
        run_one("t1", pk(9'h068, 9'h168, 9'h000, 9'h06C), pk(9'h068, 9'h168, 9'h000, 9'h06B));
        check("t1_ovf", ovf_flag, 4'b0000);
        check("t1_unf", unf_flag, 4'b0000);

        // round carry, most negative input, exponent overflow, exponent underflow
        set_lanes(10'd124, 10'h200, 10'd256, 10'd1, 4'd5, 4'd7, 4'd15, 4'd0);
        run_one("t2", pk(9'h078, 9'h1B8, 9'h0FF, 9'h008), pk(9'h06F, 9'h1B8, 9'h0FF, 9'h008));
        check("t2_ovf", ovf_flag, 4'b0100);
        check("t2_unf", unf_flag, 4'b1000);

        // tie with even mantissa, -1 landing on exp 0, exp exactly max, round carry into overflow
        set_lanes(10'd84, 10'h3FF, 10'd256, 10'd508, 4'd5, 4'd5, 4'd12, 4'd12);
        run_one("t3", pk(9'h06A, 9'h108, 9'h0F8, 9'h0FF), pk(9'h06A, 9'h108, 9'h0F8, 9'h0FF));
        check("t3_ovf_sticky", ovf_flag, 4'b1100);
        check("t3_unf_sticky", unf_flag, 4'b1000);
        check("t3_trn_ovf", t_ovf_flag, 4'b0100);

        // clear coinciding with a new overflow on lane 0: the set wins, old flags go
        set_lanes(10'd256, 10'd0, 10'd0, 10'd0, 4'd15, 4'd5, 4'd5, 4'd5);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_set_data", sfpout, pk(9'h0FF, 9'h000, 9'h000, 9'h000));
        check("clr_set_ovf", ovf_flag, 4'b0001);
        check("clr_set_unf", unf_flag, 4'b0000);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_only", {ovf_flag, unf_flag}, 8'd0);

        // 8-beat stream under backpressure pattern 1,0,0,1
        for (int c = 0; c < 100 && rcv < 8; c++) begin
            @(negedge clk);
            if (stalled) begin
                check("stall_hold", sfpout, held);
                check("stall_valid", out_valid, 1'b1);
            end
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (sent < 8) begin
                set_lanes(10'd64, 10'd64, 10'd64, 10'd64, 4'(sent + 4), 4'(sent + 4),
                          4'(sent + 4), 4'(sent + 4));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("stream_data", sfpout, {4{{1'b0, 4'(rcv + 5), 4'b1000}}});
                rcv++;
            end
            stalled = out_valid && !out_ready;
            held    = sfpout;
        end
        check("stream_count", 36'(rcv), 36'd8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("stream_no_dup", out_valid, 1'b0);

        // reset with beats in flight and a flag set
        set_lanes(10'd256, 10'd64, 10'd64, 10'd64, 4'd15, 4'd5, 4'd5, 4'd5);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_ovf", ovf_flag, 4'b0001);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_flags", {ovf_flag, unf_flag}, 8'd0);
        check("mid_rst_sfpout", sfpout, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 1'b0);
        end
        set_lanes(10'd64, 10'h3C0, 10'd64, 10'h3C0, 4'd5, 4'd5, 4'd5, 4'd5);
        run_one("post_rst", pk(9'h068, 9'h168, 9'h068, 9'h168), pk(9'h068, 9'h168, 9'h068, 9'h168));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
